// File: rtl/tiny_nn_pkg.sv
// Shared number format for the tiny NN datapath: 16-bit float {sgn, exp[7:0], mant[6:0]}, bias 127.
// Zero is any value with a zero exponent field; there are no subnormals, infinities or NaNs.
package tiny_nn_pkg;

    localparam int unsigned ExpW    = 8;
    localparam int unsigned MantW   = 7;
    localparam int unsigned FpW     = 1 + ExpW + MantW;
    localparam int unsigned ExpBias = 127;

    typedef struct packed {
        logic             sgn;
        logic [ExpW-1:0]  exp;
        logic [MantW-1:0] mant;
    } fp_t;

endpackage

// File: rtl/fp_mul.sv
// Combinational fp_t multiplier: round-to-nearest-even, zero operands/underflow give signed zero,
// exponent overflow saturates to the largest magnitude {sgn, 8'hFF, 7'h7F}.
module fp_mul
    import tiny_nn_pkg::*;
(
    input  fp_t a_i,
    input  fp_t b_i,
    output fp_t p_o
);

    logic [2*MantW+1:0] prod;
    logic signed [10:0] exp_raw;
    logic signed [10:0] exp_norm;
    logic signed [10:0] exp_fin;
    logic [MantW-1:0]   mant_t;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic [MantW:0]     mant_r;

    always_comb begin
        prod    = {8'b0, 1'b1, a_i.mant} * {8'b0, 1'b1, b_i.mant};
        exp_raw = $signed({3'b000, a_i.exp}) + $signed({3'b000, b_i.exp})
                  - $signed(11'(ExpBias));

        // Product of two [1,2) significands lies in [1,4): renormalise by at most one bit.
        if (prod[15]) begin
            mant_t   = prod[14:8];
            guard    = prod[7];
            sticky   = |prod[6:0];
            exp_norm = exp_raw + 11'sd1;
        end else begin
            mant_t   = prod[13:7];
            guard    = prod[6];
            sticky   = |prod[5:0];
            exp_norm = exp_raw;
        end

        round_up = guard & (sticky | mant_t[0]);
        mant_r   = {1'b0, mant_t} + {{MantW{1'b0}}, round_up};
        exp_fin  = mant_r[MantW] ? exp_norm + 11'sd1 : exp_norm;

        p_o.sgn  = a_i.sgn ^ b_i.sgn;
        p_o.exp  = '0;
        p_o.mant = '0;
        if (a_i.exp != '0 && b_i.exp != '0 && exp_fin > 11'sd0) begin
            if (exp_fin > 11'sd255) begin
                p_o.exp  = '1;
                p_o.mant = '1;
            end else begin
                p_o.exp  = exp_fin[ExpW-1:0];
                p_o.mant = mant_r[MantW-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Two-stage valid/ready pipeline around fp_mul: S1 registers operands, S2 registers the product.
// Counts consumed results in a wrapping CountW-bit counter.
module fp_mul_pipe
    import tiny_nn_pkg::*;
#(
    parameter int unsigned CountW = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  fp_t               op_a_i,
    input  fp_t               op_b_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output fp_t               res_o,
    output logic              busy_o,
    output logic [CountW-1:0] res_count_o
);

    logic              s1_valid_q, s1_valid_d;
    fp_t               s1_a_q, s1_a_d;
    fp_t               s1_b_q, s1_b_d;
    logic              s2_valid_q, s2_valid_d;
    fp_t               s2_res_q, s2_res_d;
    logic [CountW-1:0] res_count_q, res_count_d;

    fp_t  prod;
    logic s1_adv;
    logic op_fire;
    logic res_fire;

    fp_mul u_fp_mul (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .p_o (prod)
    );

    always_comb begin
        res_fire   = s2_valid_q & res_ready_i;
        // S1 may move into S2 in the same cycle S2 is drained, so ready ripples back from res_ready_i.
        s1_adv     = s1_valid_q & (~s2_valid_q | res_ready_i);
        op_ready_o = ~s1_valid_q | s1_adv;
        op_fire    = op_valid_i & op_ready_o;

        s1_valid_d = op_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
        s1_a_d     = op_fire ? op_a_i : s1_a_q;
        s1_b_d     = op_fire ? op_b_i : s1_b_q;

        s2_valid_d = s1_adv ? 1'b1 : (res_fire ? 1'b0 : s2_valid_q);
        s2_res_d   = s1_adv ? prod : s2_res_q;

        res_count_d = res_fire ? res_count_q + CountW'(1) : res_count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_res_q    <= '0;
            res_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_res_q    <= s2_res_d;
            res_count_q <= res_count_d;
        end
    end

    always_comb begin
        res_valid_o = s2_valid_q;
        res_o       = s2_res_q;
        busy_o      = s1_valid_q | s2_valid_q;
        res_count_o = res_count_q;
    end

endmodule
